// File: rtl/tetris_pkg.sv
// Shared types and default timing constants for the Tetris input path.
package tetris_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE   = 2'd0,
        KEY_DELAY  = 2'd1,
        KEY_REPEAT = 2'd2
    } key_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEF_REPEAT_DELAY    = 12;
    localparam int unsigned DEF_REPEAT_RATE     = 4;

    localparam int unsigned NUM_KEYS  = 3;
    localparam int unsigned KEY_LEFT  = 0;
    localparam int unsigned KEY_RIGHT = 1;
    localparam int unsigned KEY_DOWN  = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One button: synchronizer, debouncer and press/auto-repeat FSM.
// level_c and pulse_c are the next-cycle values so the top can register its outputs.
module key_channel
    import tetris_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic vclk,
    input  logic rst,
    input  logic raw,
    input  logic frame,
    output logic level,
    output logic level_c,
    output logic pulse_c
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned FC_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_DELAY = FC_W'(REPEAT_DELAY);
    localparam logic [FC_W-1:0] FC_RATE  = FC_W'(REPEAT_RATE);
    localparam logic [FC_W-1:0] FC_ONE   = FC_W'(1);

    logic            sync_a;
    logic            sync_b;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_next;
    key_state_t      state;
    key_state_t      state_next;
    logic [FC_W-1:0] frm_cnt;
    logic [FC_W-1:0] frm_cnt_next;
    logic            pulse;

    // State register for the whole channel.
    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            db_cnt  <= '0;
            state   <= KEY_IDLE;
            frm_cnt <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_a  <= raw;
            sync_b  <= sync_a;
            level   <= level_c;
            db_cnt  <= db_cnt_next;
            state   <= state_next;
            frm_cnt <= frm_cnt_next;
            pulse   <= pulse_c;
        end
    end

    // Debounce: accept a change only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        level_c     = level;
        db_cnt_next = '0;
        if (sync_b != level) begin
            if (db_cnt == DB_LAST) begin
                level_c = ~level;
            end else begin
                db_cnt_next = db_cnt + DB_W'(1);
            end
        end
    end

    // Press/repeat FSM. A frame seen while a pulse is out is ignored, which keeps
    // pulses apart and stops a frame coinciding with the press from counting.
    always_comb begin
        state_next   = state;
        frm_cnt_next = frm_cnt;
        pulse_c      = 1'b0;
        if (level_c && !level) begin
            state_next   = KEY_DELAY;
            frm_cnt_next = FC_DELAY;
            pulse_c      = 1'b1;
        end else if (!level_c) begin
            state_next   = KEY_IDLE;
            frm_cnt_next = '0;
        end else begin
            case (state)
                KEY_DELAY, KEY_REPEAT: begin
                    if (frame && !pulse) begin
                        if (frm_cnt <= FC_ONE) begin
                            state_next   = KEY_REPEAT;
                            frm_cnt_next = FC_RATE;
                            pulse_c      = 1'b1;
                        end else begin
                            frm_cnt_next = frm_cnt - FC_ONE;
                        end
                    end
                end
                default: begin
                    state_next   = KEY_IDLE;
                    frm_cnt_next = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions the three Tetris buttons into one-cycle move requests with auto-repeat.
module key_conditioner
    import tetris_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic       vclk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       frame,
    output logic       LEFT,
    output logic       RIGHT,
    output logic       DOWN,
    output logic [2:0] held
);

    logic [NUM_KEYS-1:0] raw;
    logic [NUM_KEYS-1:0] lvl;
    logic [NUM_KEYS-1:0] lvl_c;
    logic [NUM_KEYS-1:0] pls_c;
    logic                clash_c;

    assign raw = {btn_down, btn_right, btn_left};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .vclk   (vclk),
            .rst    (rst),
            .raw    (raw[i]),
            .frame  (frame),
            .level  (lvl[i]),
            .level_c(lvl_c[i]),
            .pulse_c(pls_c[i])
        );
    end

    assign held = lvl;

    // Opposing horizontal keys cancel; their FSMs keep running underneath.
    assign clash_c = lvl_c[KEY_LEFT] & lvl_c[KEY_RIGHT];

    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            LEFT  <= 1'b0;
            RIGHT <= 1'b0;
            DOWN  <= 1'b0;
        end else begin
            LEFT  <= pls_c[KEY_LEFT] & ~clash_c;
            RIGHT <= pls_c[KEY_RIGHT] & ~clash_c;
            DOWN  <= pls_c[KEY_DOWN];
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce and repeat constants.
module tb_key_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 3;
    localparam int unsigned RR = 2;

    logic       vclk = 1'b0;
    logic       rst;
    logic       btn_left;
    logic       btn_right;
    logic       btn_down;
    logic       frame;
    logic       LEFT;
    logic       RIGHT;
    logic       DOWN;
    logic [2:0] held;

    int n_checks = 0;
    int n_errors = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .vclk     (vclk),
        .rst      (rst),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_down (btn_down),
        .frame    (frame),
        .LEFT     (LEFT),
        .RIGHT    (RIGHT),
        .DOWN     (DOWN),
        .held     (held)
    );

    always #5 vclk = ~vclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs for the next edge, then sample just after it.
    task automatic step(input logic l, input logic r, input logic d, input logic f);
        btn_left  = l;
        btn_right = r;
        btn_down  = d;
        frame     = f;
        @(posedge vclk);
        #1;
    endtask

    // pulses = {LEFT,RIGHT,DOWN}; lvls = {down,right,left}
    task automatic expect_out(input string tag, input int k, input logic [2:0] pulses,
                              input logic [2:0] lvls);
        chk($sformatf("%s.pulse@%0d", tag, k), 32'({LEFT, RIGHT, DOWN}), 32'(pulses));
        chk($sformatf("%s.held@%0d", tag, k), 32'(held), 32'(lvls));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset with every input active: nothing may leak through.
        rst = 1'b1;
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
        expect_out("reset", 0, 3'b000, 3'b000);
        do_reset();

        // Left held 60 cycles, frame every 10: press, 3rd frame, 5th frame.
        for (int k = 1; k <= 100; k++) begin
            step(k <= 60, 1'b0, 1'b0, (k % 10) == 0);
            expect_out("hold", k, {(k == 6 || k == 30 || k == 50), 2'b00},
                       {2'b00, (k >= 6 && k <= 65)});
        end

        // Down glitches of 2 and 3 cycles are rejected; 4 cycles is accepted.
        for (int len = 2; len <= 4; len++) begin
            do_reset();
            for (int k = 1; k <= 14; k++) begin
                step(1'b0, 1'b0, k <= len, 1'b0);
                expect_out($sformatf("glitch%0d", len), k,
                           {2'b00, (len == 4 && k == 6)},
                           {(len == 4 && k >= 6 && k <= 9), 2'b00});
            end
        end

        // Left+right together cancel; right released, left resumes on schedule.
        do_reset();
        for (int k = 1; k <= 75; k++) begin
            step(1'b1, k < 35, 1'b0, (k % 10) == 0);
            expect_out("clash", k, {(k == 50 || k == 70), 2'b00},
                       {1'b0, (k >= 6 && k <= 39), (k >= 6)});
        end

        // Down held while left is tapped twice: independent and coincident pulses.
        do_reset();
        for (int k = 1; k <= 55; k++) begin
            step((k <= 7) || (k >= 25 && k <= 40), 1'b0, 1'b1, (k % 10) == 0);
            expect_out("combo", k,
                       {(k == 6 || k == 30), 1'b0, (k == 6 || k == 30 || k == 50)},
                       {(k >= 6), 1'b0, ((k >= 6 && k <= 12) || (k >= 30 && k <= 45))});
        end

        // Reset while a repeat pulse is out, button still held.
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            step(1'b1, 1'b0, 1'b0, (k % 10) == 0);
            expect_out("abort", k, {(k == 6 || k == 30), 2'b00}, {2'b00, (k >= 6)});
        end
        rst = 1'b1;
        #1;
        expect_out("abort.async", 0, 3'b000, 3'b000);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            expect_out("abort.inrst", k, 3'b000, 3'b000);
        end
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            expect_out("abort.after", k, {(k == 6), 2'b00}, {2'b00, (k >= 6)});
        end

        // Acceptance coincides with a frame: that frame does not count.
        do_reset();
        for (int k = 1; k <= 58; k++) begin
            step(1'b1, 1'b0, 1'b0, (k % 10) == 6);
            expect_out("coinc", k, {(k == 6 || k == 36 || k == 56), 2'b00},
                       {2'b00, (k >= 6)});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
